ysyx_23060240_lsu: RTL and testbench

Load/store unit that sits directly upstream of the data-memory stage. It accepts one memory operation at a time from the execute stage and checks alignment. It then issues a single request to the data-memory port, with the write data lane-shifted and a byte mask, and waits for the response. Load data is shifted and sign- or zero-extended before being handed to write-back with a valid/ready handshake.

---
 rtl/ysyx_23060240_pkg.sv | 41 ++++
 rtl/ysyx_23060240_lsu_align.sv | 58 +++++
 rtl/ysyx_23060240_lsu.sv | 146 ++++++++++++++
 tb/tb_ysyx_23060240_lsu.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060240_pkg.sv
// rtl/ysyx_23060240_pkg.sv - shared ctrl codes, LSU state enum and access-size helpers
package ysyx_23060240_pkg;

    // Same encoding as the memory stage's memory_rd_ctrl field.
    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_LH  = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;
    localparam logic [2:0] OP_LW  = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT,
        LSU_RESP
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } lsu_size_t;

    // Stores only define 001/011/101; every other code falls back to word width.
    function automatic lsu_size_t op_size(input logic [2:0] op, input logic is_store);
        lsu_size_t size;
        case (op)
            OP_LB:   size = SZ_BYTE;
            OP_LBU:  size = is_store ? SZ_WORD : SZ_BYTE;
            OP_LH:   size = SZ_HALF;
            OP_LHU:  size = is_store ? SZ_WORD : SZ_HALF;
            default: size = SZ_WORD;
        endcase
        return size;
    endfunction

    function automatic logic op_signed(input logic [2:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

endpackage

// File: rtl/ysyx_23060240_lsu_align.sv
// rtl/ysyx_23060240_lsu_align.sv - store lane shift/mask, load shift/extend, alignment check
module ysyx_23060240_lsu_align
    import ysyx_23060240_pkg::*;
(
    input  logic [2:0]  op,
    input  logic        is_store,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] raw_data,
    output logic [31:0] lane_wdata,
    output logic [7:0]  wmask,
    output logic [31:0] load_data,
    output logic        misalign
);

    lsu_size_t   size;
    logic [3:0]  base_mask;
    logic [3:0]  lane_mask;
    logic [31:0] shifted;
    logic        sext;

    assign size = op_size(op, is_store);
    assign sext = op_signed(op);

    always_comb begin
        base_mask = 4'b1111;
        misalign  = 1'b0;
        case (size)
            SZ_BYTE: begin
                base_mask = 4'b0001;
                misalign  = 1'b0;
            end
            SZ_HALF: begin
                base_mask = 4'b0011;
                misalign  = addr_lo[0];
            end
            default: begin
                base_mask = 4'b1111;
                misalign  = |addr_lo;
            end
        endcase
    end

    assign lane_mask  = base_mask << addr_lo;
    assign wmask      = {4'b0000, lane_mask};
    assign lane_wdata = store_data << {addr_lo, 3'b000};
    assign shifted    = raw_data >> {addr_lo, 3'b000};

    always_comb begin
        load_data = shifted;
        case (size)
            SZ_BYTE: load_data = {{24{sext & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data = {{16{sext & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_23060240_lsu.sv
// rtl/ysyx_23060240_lsu.sv - single-outstanding load/store unit sequencing FSM
module ysyx_23060240_lsu
    import ysyx_23060240_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_store,
    input  logic [2:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [4:0]        in_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [7:0]        mem_req_wmask,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rdata,
    output logic [4:0]        out_rd,
    output logic              out_we,
    output logic              out_misalign
);

    lsu_state_t  state;
    logic [2:0]  op_q;
    logic        store_q;
    logic [1:0]  addr_lo_q;
    logic [4:0]  rd_q;

    logic        idle;
    logic [2:0]  al_op;
    logic        al_store;
    logic [1:0]  al_addr_lo;
    logic [31:0] al_wdata;
    logic [7:0]  al_wmask;
    logic [31:0] al_load;
    logic        al_misalign;

    // One align instance: fed from the inputs while accepting, from latched fields afterwards.
    assign idle       = (state == LSU_IDLE);
    assign al_op      = idle ? in_op       : op_q;
    assign al_store   = idle ? in_is_store : store_q;
    assign al_addr_lo = idle ? in_addr[1:0] : addr_lo_q;

    ysyx_23060240_lsu_align u_align (
        .op         (al_op),
        .is_store   (al_store),
        .addr_lo    (al_addr_lo),
        .store_data (in_wdata),
        .raw_data   (mem_rsp_rdata),
        .lane_wdata (al_wdata),
        .wmask      (al_wmask),
        .load_data  (al_load),
        .misalign   (al_misalign)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= LSU_IDLE;
            op_q          <= '0;
            store_q       <= 1'b0;
            addr_lo_q     <= '0;
            rd_q          <= '0;
            in_ready      <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
            out_valid     <= 1'b0;
            out_rdata     <= '0;
            out_rd        <= '0;
            out_we        <= 1'b0;
            out_misalign  <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (in_valid) begin
                        op_q      <= in_op;
                        store_q   <= in_is_store;
                        addr_lo_q <= in_addr[1:0];
                        rd_q      <= in_rd;
                        in_ready  <= 1'b0;
                        if (al_misalign) begin
                            state        <= LSU_RESP;
                            out_valid    <= 1'b1;
                            out_misalign <= 1'b1;
                            out_we       <= 1'b0;
                            out_rdata    <= '0;
                            out_rd       <= in_rd;
                        end else begin
                            state         <= LSU_REQ;
                            mem_req_valid <= 1'b1;
                            mem_req_we    <= in_is_store;
                            mem_req_addr  <= in_addr;
                            mem_req_wdata <= al_wdata;
                            mem_req_wmask <= al_wmask;
                        end
                    end
                end
                LSU_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        if (mem_rsp_valid) begin
                            state        <= LSU_RESP;
                            out_valid    <= 1'b1;
                            out_misalign <= 1'b0;
                            out_we       <= !store_q;
                            out_rdata    <= store_q ? '0 : al_load;
                            out_rd       <= rd_q;
                        end else begin
                            state <= LSU_WAIT;
                        end
                    end
                end
                LSU_WAIT: begin
                    if (mem_rsp_valid) begin
                        state        <= LSU_RESP;
                        out_valid    <= 1'b1;
                        out_misalign <= 1'b0;
                        out_we       <= !store_q;
                        out_rdata    <= store_q ? '0 : al_load;
                        out_rd       <= rd_q;
                    end
                end
                LSU_RESP: begin
                    if (out_ready) begin
                        state     <= LSU_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060240_lsu.sv
// tb/tb_ysyx_23060240_lsu.sv - self-checking bench for ysyx_23060240_lsu
module tb_ysyx_23060240_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_store;
    logic [2:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_misalign;

    always #5 clk = ~clk;

    ysyx_23060240_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_is_store   (in_is_store),
        .in_op         (in_op),
        .in_addr       (in_addr),
        .in_wdata      (in_wdata),
        .in_rd         (in_rd),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wmask (mem_req_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rdata     (out_rdata),
        .out_rd        (out_rd),
        .out_we        (out_we),
        .out_misalign  (out_misalign)
    );

    typedef struct {
        logic        st;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rsp;
        logic [31:0] exp_wdata;
        logic [7:0]  exp_wmask;
        logic [31:0] exp_rdata;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        we;
        logic        mis;
    } exp_t;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid      = 1'b0;
        in_is_store   = 1'b0;
        in_op         = 3'b000;
        in_addr       = 32'h0;
        in_wdata      = 32'h0;
        in_rd         = 5'd0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'h0;
        out_ready     = 1'b0;
    endtask

    task automatic drive_op(input logic st, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] rd,
                            input logic [31:0] exp_rdata, input logic mis);
        exp_t e;
        in_valid    = 1'b1;
        in_is_store = st;
        in_op       = op;
        in_addr     = addr;
        in_wdata    = wdata;
        in_rd       = rd;
        e.rdata = exp_rdata;
        e.rd    = rd;
        e.we    = !st && !mis;
        e.mis   = mis;
        exp_q.push_back(e);
    endtask

    // Waits (bounded) for out_valid, then pops the scoreboard and completes the handshake.
    task automatic consume(input string tag);
        exp_t e;
        int   n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            tests++;
            fails++;
            $display("FAIL %s.timeout: out_valid never rose", tag);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            return;
        end
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s.scoreboard: unexpected output, queue empty", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".rdata"}, out_rdata, e.rdata);
            chk({tag, ".rd"}, {27'b0, out_rd}, {27'b0, e.rd});
            chk({tag, ".we"}, {31'b0, out_we}, {31'b0, e.we});
            chk({tag, ".mis"}, {31'b0, out_misalign}, {31'b0, e.mis});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".out_valid_drop"}, {31'b0, out_valid}, 32'd0);
        chk({tag, ".in_ready_back"}, {31'b0, in_ready}, 32'd1);
    endtask

    task automatic run_vec(input int i);
        vec_t  v;
        string tag;
        v   = vecs[i];
        tag = $sformatf("vec%0d", i);
        drive_op(v.st, v.op, v.addr, v.wdata, 5'(i + 1), v.exp_rdata, v.exp_mis);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".in_ready_low"}, {31'b0, in_ready}, 32'd0);
        if (!v.exp_mis) begin
            chk({tag, ".req_valid"}, {31'b0, mem_req_valid}, 32'd1);
            chk({tag, ".req_we"}, {31'b0, mem_req_we}, {31'b0, v.st});
            chk({tag, ".req_addr"}, mem_req_addr, v.addr);
            if (v.st) begin
                chk({tag, ".wdata"}, mem_req_wdata, v.exp_wdata);
                chk({tag, ".wmask"}, {24'b0, mem_req_wmask}, {24'b0, v.exp_wmask});
            end
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            chk({tag, ".req_drop"}, {31'b0, mem_req_valid}, 32'd0);
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = v.rsp;
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            mem_rsp_rdata = 32'h0;
        end else begin
            chk({tag, ".no_req"}, {31'b0, mem_req_valid}, 32'd0);
        end
        chk({tag, ".latency"}, {31'b0, out_valid}, 32'd1);
        consume(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //          st    op      addr          wdata         rsp           exp_wdata     mask   exp_rdata     mis
        vecs[0]  = '{1'b1, 3'b101, 32'h80000004, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 8'h0F, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 3'b001, 32'h80000003, 32'h000000A5, 32'h0,        32'hA5000000, 8'h08, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 3'b001, 32'h80000002, 32'h0,        32'h12F03456, 32'h0,        8'h00, 32'hFFFFFFF0, 1'b0};
        vecs[3]  = '{1'b0, 3'b010, 32'h80000002, 32'h0,        32'h12F03456, 32'h0,        8'h00, 32'h000000F0, 1'b0};
        vecs[4]  = '{1'b0, 3'b011, 32'h80000002, 32'h0,        32'h12F03456, 32'h0,        8'h00, 32'h000012F0, 1'b0};
        vecs[5]  = '{1'b0, 3'b101, 32'h80000006, 32'h0,        32'h0,        32'h0,        8'h00, 32'h0,        1'b1};
        vecs[6]  = '{1'b0, 3'b101, 32'h80000008, 32'h0,        32'hCAFEF00D, 32'h0,        8'h00, 32'hCAFEF00D, 1'b0};
        vecs[7]  = '{1'b0, 3'b100, 32'h80000002, 32'h0,        32'h80017777, 32'h0,        8'h00, 32'h00008001, 1'b0};
        vecs[8]  = '{1'b0, 3'b011, 32'h80000000, 32'h0,        32'h0000F00F, 32'h0,        8'h00, 32'hFFFFF00F, 1'b0};
        vecs[9]  = '{1'b1, 3'b011, 32'h80000002, 32'h1234ABCD, 32'h0,        32'hABCD0000, 8'h0C, 32'h0,        1'b0};
        vecs[10] = '{1'b1, 3'b011, 32'h80000001, 32'h1234ABCD, 32'h0,        32'h0,        8'h00, 32'h0,        1'b1};
        vecs[11] = '{1'b0, 3'b001, 32'h80000001, 32'h0,        32'h00008000, 32'h0,        8'h00, 32'hFFFFFF80, 1'b0};
        vecs[12] = '{1'b0, 3'b111, 32'h80000000, 32'h0,        32'h11223344, 32'h0,        8'h00, 32'h11223344, 1'b0};
        vecs[13] = '{1'b1, 3'b010, 32'h80000002, 32'h55667788, 32'h0,        32'h0,        8'h00, 32'h0,        1'b1};

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset.in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset.req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("reset.req_addr", mem_req_addr, 32'd0);
        chk("reset.req_wmask", {24'b0, mem_req_wmask}, 32'd0);
        chk("reset.out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset.out_rdata", out_rdata, 32'd0);

        for (int i = 0; i < 14; i++) run_vec(i);

        // Backpressure on both sides, plus a stray response while the request is not yet taken.
        drive_op(1'b0, 3'b100, 32'h80000002, 32'h0, 5'd21, 32'h00009ABC, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp.req_hold%0d.valid", c), {31'b0, mem_req_valid}, 32'd1);
            chk($sformatf("bp.req_hold%0d.addr", c), mem_req_addr, 32'h80000002);
            chk($sformatf("bp.req_hold%0d.mask", c), {24'b0, mem_req_wmask}, 32'h0C);
            chk($sformatf("bp.req_hold%0d.we", c), {31'b0, mem_req_we}, 32'd0);
            chk($sformatf("bp.req_hold%0d.in_ready", c), {31'b0, in_ready}, 32'd0);
            mem_rsp_valid = (c == 1);
            mem_rsp_rdata = 32'hFFFFFFFF;
            @(negedge clk);
        end
        mem_rsp_valid = 1'b0;
        chk("bp.stray_rsp_ignored", {31'b0, out_valid}, 32'd0);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("bp.req_drop", {31'b0, mem_req_valid}, 32'd0);
        @(negedge clk);
        chk("bp.wait1", {31'b0, out_valid}, 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h9ABC5678;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'h0;
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("bp.out_hold%0d.valid", c), {31'b0, out_valid}, 32'd1);
            chk($sformatf("bp.out_hold%0d.rdata", c), out_rdata, 32'h00009ABC);
            chk($sformatf("bp.out_hold%0d.in_ready", c), {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        consume("bp");

        // Reset while waiting for the response.
        drive_op(1'b0, 3'b101, 32'h80000010, 32'h0, 5'd9, 32'h0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        void'(exp_q.pop_front());
        rst = 1'b1;
        #1;
        chk("rstw.in_ready_async", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstw.in_ready", {31'b0, in_ready}, 32'd1);
        chk("rstw.req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rstw.req_addr", mem_req_addr, 32'd0);
        chk("rstw.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rstw.out_rd", {27'b0, out_rd}, 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h77777777;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("rstw.late_rsp%0d", c), {31'b0, out_valid}, 32'd0);
            @(negedge clk);
        end
        chk("rstw.in_ready_after", {31'b0, in_ready}, 32'd1);

        // Unit remains usable after the mid-operation reset.
        run_vec(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
